// File: rtl/shift_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// shift_deserializer_pkg
// Shared definitions for the shift deserializer slice:
//   - DEFAULT_WIDTH : default word width in bits
//   - DIR_*         : encoding of the bit-order select input
//   - state_t       : output buffer state (EMPTY = no word held, FULL = word held)
// -----------------------------------------------------------------------------
package shift_deserializer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic DIR_MSB_FIRST = 1'b0;  // shift left, new bit enters LSB
  localparam logic DIR_LSB_FIRST = 1'b1;  // shift right, new bit enters MSB

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage : shift_deserializer_pkg

// File: rtl/shift_deserializer_if.sv
// -----------------------------------------------------------------------------
// shift_deserializer_if
// Bundles the serial input side and the parallel output side of the
// deserializer.
//   slave  : the deserializer itself (consumes bits, produces words)
//   master : the environment (drives bits, consumes words)
//
// Handshake: a word transfers on every rising clk edge where
// word_valid && word_ready are both 1. word_valid never drops without a
// transfer (or reset); word_out is stable while word_valid=1 and no transfer
// happens. The serial side has no back-pressure: a bit with bit_valid=1 is
// always consumed on that edge.
// -----------------------------------------------------------------------------
interface shift_deserializer_if #(
  parameter int WIDTH = shift_deserializer_pkg::DEFAULT_WIDTH
);
  logic             bit_in;
  logic             bit_valid;
  logic             dir;
  logic             flush;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic             overflow;

  modport slave (
    input  bit_in, bit_valid, dir, flush, word_ready,
    output word_out, word_valid, busy, overflow
  );

  modport master (
    output bit_in, bit_valid, dir, flush, word_ready,
    input  word_out, word_valid, busy, overflow
  );
endinterface : shift_deserializer_if

// File: rtl/shift_accumulator.sv
// -----------------------------------------------------------------------------
// shift_accumulator
// Collects serial bits into a WIDTH-bit word. The bit order is latched from
// `dir` on the first valid bit of each word and held for the rest of it.
// Ports:
//   clk, clear_b  : clock, synchronous active-low reset
//   bit_in        : serial data bit
//   bit_valid     : bit_in is consumed this cycle
//   dir           : bit order for a new word (see DIR_* in the package)
//   flush         : discard the partial word (a same-cycle bit is dropped too)
//   acc_word      : word including the current bit; meaningful when acc_done=1
//   acc_done      : 1 in the cycle the WIDTH-th valid bit is presented
//   busy          : registered, 1 while a partial word is held (counter != 0)
// -----------------------------------------------------------------------------
module shift_accumulator
  import shift_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear_b,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             dir,
  input  logic             flush,
  output logic [WIDTH-1:0] acc_word,
  output logic             acc_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;
  logic             r_busy;

  logic             w_dir;
  logic             w_last;
  logic             w_take;
  logic [WIDTH-1:0] w_shift;

  // The first bit of a word uses the live dir input; later bits use the latch.
  assign w_dir   = (r_cnt == '0) ? dir : r_dir;
  assign w_shift = (w_dir == DIR_LSB_FIRST) ? {bit_in, r_acc[WIDTH-1:1]}
                                            : {r_acc[WIDTH-2:0], bit_in};
  assign w_last  = (r_cnt == LAST);
  assign w_take  = clear_b && bit_valid && !flush;

  assign acc_word = w_shift;
  assign acc_done = w_take && w_last;
  assign busy     = r_busy;

  always_ff @(posedge clk) begin
    if (!clear_b) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_dir  <= DIR_MSB_FIRST;
      r_busy <= 1'b0;
    end else if (flush) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (bit_valid) begin
      if (r_cnt == '0) r_dir <= dir;
      if (w_last) begin
        // Completed word leaves through acc_word; start the next one clean.
        r_acc  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end else begin
        r_acc  <= w_shift;
        r_cnt  <= r_cnt + 1'b1;
        r_busy <= 1'b1;
      end
    end
  end

endmodule : shift_accumulator

// File: rtl/shift_deserializer.sv
// -----------------------------------------------------------------------------
// shift_deserializer
// Serial-to-parallel converter with a one-word output buffer. The accumulator
// keeps collecting while a finished word waits in the buffer; a word that
// completes while the buffer is held and not being drained is dropped and
// sets the sticky overflow flag.
// Ports:
//   clk         : clock, rising edge
//   clear_b     : synchronous active-low reset, priority over all inputs
//   bus         : shift_deserializer_if.slave (bits in, words out, status)
//   o_dbg_state : buffer state (EMPTY/FULL) for observation
// -----------------------------------------------------------------------------
module shift_deserializer
  import shift_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  clear_b,
  shift_deserializer_if.slave   bus,
  output state_t                o_dbg_state
);

  logic [WIDTH-1:0] w_acc_word;
  logic             w_acc_done;
  logic             w_busy;

  state_t           r_state;
  logic [WIDTH-1:0] r_word;
  logic             r_word_valid;
  logic             r_overflow;

  shift_accumulator #(.WIDTH(WIDTH)) u_acc (
    .clk       (clk),
    .clear_b   (clear_b),
    .bit_in    (bus.bit_in),
    .bit_valid (bus.bit_valid),
    .dir       (bus.dir),
    .flush     (bus.flush),
    .acc_word  (w_acc_word),
    .acc_done  (w_acc_done),
    .busy      (w_busy)
  );

  // r_word_valid mirrors r_state so the output is a plain flop.
  always_ff @(posedge clk) begin
    if (!clear_b) begin
      r_state      <= EMPTY;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc_done) begin
            r_word       <= w_acc_word;
            r_word_valid <= 1'b1;
            r_state      <= FULL;
          end
        end
        FULL: begin
          if (w_acc_done) begin
            if (bus.word_ready) begin
              // Old word drains and the new one takes its place in one edge.
              r_word <= w_acc_word;
            end else begin
              r_overflow <= 1'b1;
            end
          end else if (bus.word_ready) begin
            r_word_valid <= 1'b0;
            r_state      <= EMPTY;
          end
        end
        default: begin
          r_state      <= EMPTY;
          r_word_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.word_out   = r_word;
  assign bus.word_valid = r_word_valid;
  assign bus.busy       = w_busy;
  assign bus.overflow   = r_overflow;
  assign o_dbg_state    = r_state;

endmodule : shift_deserializer
